// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Flush/stall controller for the Aquila FET/DEC/EXE/MEM/WB
//               pipeline. Tracks outstanding loads in a small scoreboard,
//               holds the pipe while a multi-cycle mul/div runs, freezes on
//               D-memory wait and stretches the front-end flush after a
//               trap/mret redirect.
// Config      : define BRANCH_PREDICTOR_EN to suppress branch flushes for
//               branches the BPU already predicted correctly.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
  parameter int RA_W       = 5,  // register address width
  parameter int LOAD_LAT   = 2,  // cycles until load data is forwardable (1..7)
  parameter int SB_DEPTH   = 2,  // outstanding-load scoreboard entries (1..4)
  parameter int FLUSH_HOLD = 2   // extra front-end flush cycles after sys jump (1..7)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [RA_W-1:0] rs1_addr_i,
  input  logic            rs1_used_i,
  input  logic [RA_W-1:0] rs2_addr_i,
  input  logic            rs2_used_i,
  input  logic            illegal_instr_i,
  input  logic            dec_is_load_i,
  input  logic [RA_W-1:0] dec_rd_addr_i,
  input  logic            dec_is_muldiv_i,
  input  logic            muldiv_done_i,
  input  logic            dmem_stall_i,
  input  logic            branch_taken_i,
  input  logic            cond_branch_hit_i,
  input  logic            uncond_branch_hit_i,
  input  logic            cond_mispredict_i,
  input  logic            sys_jump_i,
  output logic            flush2fet_o,
  output logic            flush2dec_o,
  output logic            flush2exe_o,
  output logic            flush2mem_o,
  output logic            stall_front_o,
  output logic            stall_back_o,
  output logic            sb_full_o
);

  localparam logic [2:0] LAT_INIT  = 3'(LOAD_LAT);
  localparam logic [2:0] HOLD_INIT = 3'(FLUSH_HOLD);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MULDIV = 2'd1,
    ST_FLUSH  = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [2:0]          hold_cnt;
  logic [2:0]          hold_cnt_nxt;

  logic [SB_DEPTH-1:0] sb_valid;
  logic [SB_DEPTH-1:0] sb_hit;
  logic [SB_DEPTH-1:0] alloc_sel;
  logic                load_use;
  logic                sb_full;
  logic                alloc_req;
  logic                sb_full_need;
  logic                alloc_en;
  logic                branch_flush;
  logic                stall_back;
  logic                stall_front;
  logic                flush_fet;
  logic                flush_dec;

  // --------------------------------------------------------------------------
  // Branch flush source: with a predictor, only unpredicted taken branches
  // and mispredicted conditional branches need to redirect the front end.
  // --------------------------------------------------------------------------
`ifdef BRANCH_PREDICTOR_EN
  assign branch_flush = (branch_taken_i & ~cond_branch_hit_i & ~uncond_branch_hit_i)
                      | cond_mispredict_i;
`else
  logic unused_bp_inputs;
  assign branch_flush     = branch_taken_i;
  assign unused_bp_inputs = cond_branch_hit_i ^ uncond_branch_hit_i ^ cond_mispredict_i;
`endif

  // --------------------------------------------------------------------------
  // Load scoreboard. Each entry remembers the destination of a load that has
  // left DEC and counts down until its data can be forwarded.
  // --------------------------------------------------------------------------
  generate
    for (genvar i = 0; i < SB_DEPTH; i++) begin : g_entry
      logic            vld;
      logic [RA_W-1:0] rd;
      logic [2:0]      cnt;

      // Allocate, age (frozen by D-memory wait) and clear on redirect.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          vld <= 1'b0;
          rd  <= '0;
          cnt <= '0;
        end else if (sys_jump_i) begin
          vld <= 1'b0;
          cnt <= '0;
        end else if (alloc_sel[i]) begin
          vld <= 1'b1;
          rd  <= dec_rd_addr_i;
          cnt <= LAT_INIT;
        end else if (vld && !dmem_stall_i) begin
          if (cnt == 3'd1) begin
            vld <= 1'b0;
            cnt <= '0;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
      end

      assign sb_valid[i] = vld;
      // x0 is hard-wired zero, so it can never carry a load-use dependency.
      assign sb_hit[i]   = vld & ((rs1_used_i & (rs1_addr_i != '0) & (rd == rs1_addr_i))
                                | (rs2_used_i & (rs2_addr_i != '0) & (rd == rs2_addr_i)));
    end
  endgenerate

  assign load_use     = |sb_hit;
  assign sb_full      = &sb_valid;
  assign alloc_req    = dec_is_load_i & (dec_rd_addr_i != '0);
  assign sb_full_need = alloc_req & sb_full;
  // A load only claims an entry when it really leaves DEC this cycle.
  assign alloc_en     = alloc_req & ~stall_front & ~flush_dec & ~dmem_stall_i & ~sys_jump_i;

  // Pick the lowest-numbered free entry for a new load.
  always_comb begin
    logic found;
    found     = 1'b0;
    alloc_sel = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (alloc_en && !sb_valid[i] && !found) begin
        alloc_sel[i] = 1'b1;
        found        = 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM: mul/div busy tracking and the stretched sys-jump flush.
  // --------------------------------------------------------------------------

  // State and flush-hold counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= ST_IDLE;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_cnt_nxt;
    end
  end

  // Stall/flush generation and next-state selection.
  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;

    stall_back  = dmem_stall_i | ((state == ST_MULDIV) & ~muldiv_done_i);
    stall_front = stall_back | load_use | sb_full_need;
    flush_fet   = ~dmem_stall_i & (branch_flush | sys_jump_i | (state == ST_FLUSH));
    // A DEC-side hazard becomes a bubble only if the back end keeps moving.
    flush_dec   = ~dmem_stall_i & (branch_flush | sys_jump_i | (state == ST_FLUSH)
                | ((load_use | sb_full_need | illegal_instr_i) & ~stall_back));

    case (state)
      ST_IDLE: begin
        if (sys_jump_i) begin
          state_nxt    = ST_FLUSH;
          hold_cnt_nxt = HOLD_INIT;
        end else if (dec_is_muldiv_i && !stall_front) begin
          state_nxt = ST_MULDIV;
        end
      end
      ST_MULDIV: begin
        // A redirect abandons the running mul/div.
        if (sys_jump_i) begin
          state_nxt    = ST_FLUSH;
          hold_cnt_nxt = HOLD_INIT;
        end else if (muldiv_done_i) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        if (sys_jump_i) begin
          hold_cnt_nxt = HOLD_INIT;
        end else if (hold_cnt <= 3'd1) begin
          state_nxt    = ST_IDLE;
          hold_cnt_nxt = '0;
        end else begin
          hold_cnt_nxt = hold_cnt - 3'd1;
        end
      end
      default: begin
        state_nxt    = ST_IDLE;
        hold_cnt_nxt = '0;
      end
    endcase
  end

  // Outputs are forced low while reset is asserted.
  assign stall_back_o  = rst_ni & stall_back;
  assign stall_front_o = rst_ni & stall_front;
  assign flush2fet_o   = rst_ni & flush_fet;
  assign flush2dec_o   = rst_ni & flush_dec;
  assign flush2exe_o   = rst_ni & sys_jump_i;
  assign flush2mem_o   = rst_ni & sys_jump_i;
  assign sb_full_o     = rst_ni & sb_full;

`ifndef SYNTHESIS
  // At most one entry is claimed per cycle, and FLUSH always has cycles left.
  a_alloc_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(alloc_sel));
  a_flush_cnt: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state != ST_FLUSH) || (hold_cnt != 3'd0));
`endif

endmodule
`default_nettype wire
